// File: rtl/pc_gen_btb_pkg.sv
// Shared fetch-stage types: BTB counter encoding, next-PC source select and
// helpers that slice a PC into BTB index and tag fields.
package cpu_pkg;

    localparam int unsigned PC_ALIGN_BITS = 2;
    localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

    typedef logic [1:0] btb_ctr_t;

    localparam btb_ctr_t BTB_CTR_STRONG_NT   = 2'b00;
    localparam btb_ctr_t BTB_CTR_WEAK_TAKEN  = 2'b10;
    localparam btb_ctr_t BTB_CTR_STRONG_TKN  = 2'b11;

    typedef enum logic [2:0] {
        NPC_TRAP,
        NPC_REDIRECT,
        NPC_HOLD,
        NPC_PRED,
        NPC_SEQ
    } npc_src_t;

    // Returned widths are generous; callers size-cast to their own field width.
    function automatic int unsigned btb_idx(input logic [63:0] pc, input int unsigned idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return int'((pc >> PC_ALIGN_BITS) & mask);
    endfunction

    function automatic logic [63:0] btb_tag(input logic [63:0] pc, input int unsigned idx_w);
        return pc >> (PC_ALIGN_BITS + idx_w);
    endfunction

    function automatic btb_ctr_t ctr_next(input btb_ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == BTB_CTR_STRONG_TKN) ? ctr : ctr + 2'd1;
        end
        return (ctr == BTB_CTR_STRONG_NT) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/pc_gen_btb_if.sv
// Fetch-side bundle: redirect/trap/stall controls, BTB update port and the
// PC/prediction outputs. The master drives controls, the slave is the PC generator.
interface pc_gen_btb_if #(
    parameter int unsigned WIDTH_P = 32
) ();

    logic               stall_i;
    logic               trap_i;
    logic [WIDTH_P-1:0] trap_vec_i;
    logic               redirect_i;
    logic [WIDTH_P-1:0] redirect_pc_i;
    logic               upd_valid_i;
    logic [WIDTH_P-1:0] upd_pc_i;
    logic [WIDTH_P-1:0] upd_target_i;
    logic               upd_taken_i;
    logic               btb_flush_i;
    logic [WIDTH_P-1:0] pc_o;
    logic               pred_taken_o;
    logic [WIDTH_P-1:0] pred_target_o;

    modport master (
        output stall_i, trap_i, trap_vec_i, redirect_i, redirect_pc_i,
        output upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i, btb_flush_i,
        input  pc_o, pred_taken_o, pred_target_o
    );

    modport slave (
        input  stall_i, trap_i, trap_vec_i, redirect_i, redirect_pc_i,
        input  upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i, btb_flush_i,
        output pc_o, pred_taken_o, pred_target_o
    );

endinterface

// File: rtl/pc_gen_btb_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational and sees pre-update contents; updates land on the edge.
module branch_target_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH_P     = 32,
    parameter int unsigned BTB_DEPTH_P = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [WIDTH_P-1:0] lookup_pc_i,
    output logic               pred_taken_o,
    output logic [WIDTH_P-1:0] pred_target_o,
    input  logic               upd_valid_i,
    input  logic [WIDTH_P-1:0] upd_pc_i,
    input  logic [WIDTH_P-1:0] upd_target_i,
    input  logic               upd_taken_i,
    input  logic               flush_i
);

    localparam int unsigned IDX_W = $clog2(BTB_DEPTH_P);
    localparam int unsigned TAG_W = WIDTH_P - IDX_W - PC_ALIGN_BITS;
    localparam int unsigned TGT_W = WIDTH_P - PC_ALIGN_BITS;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [TGT_W-1:0] target;
        btb_ctr_t         ctr;
    } btb_entry_t;

    logic [BTB_DEPTH_P-1:0] valid_d, valid_q;
    btb_entry_t             entries_d [BTB_DEPTH_P];
    btb_entry_t             entries_q [BTB_DEPTH_P];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic [TGT_W-1:0] wr_target;
    btb_entry_t       rd_entry, wr_entry;
    logic             rd_hit, wr_hit;

    always_comb begin
        rd_idx   = IDX_W'(btb_idx(64'(lookup_pc_i), IDX_W));
        rd_tag   = TAG_W'(btb_tag(64'(lookup_pc_i), IDX_W));
        rd_entry = entries_q[rd_idx];
        rd_hit   = valid_q[rd_idx] && (rd_entry.tag == rd_tag);

        pred_taken_o  = rd_hit && rd_entry.ctr[1];
        pred_target_o = pred_taken_o ? {rd_entry.target, {PC_ALIGN_BITS{1'b0}}} : '0;
    end

    always_comb begin
        valid_d   = valid_q;
        entries_d = entries_q;

        wr_idx    = IDX_W'(btb_idx(64'(upd_pc_i), IDX_W));
        wr_tag    = TAG_W'(btb_tag(64'(upd_pc_i), IDX_W));
        wr_target = TGT_W'(upd_target_i >> PC_ALIGN_BITS);
        wr_entry  = entries_q[wr_idx];
        wr_hit    = valid_q[wr_idx] && (wr_entry.tag == wr_tag);

        // Flush takes precedence: a same-cycle update is dropped.
        if (flush_i) begin
            valid_d = '0;
        end else if (upd_valid_i) begin
            if (wr_hit) begin
                entries_d[wr_idx].ctr = ctr_next(wr_entry.ctr, upd_taken_i);
                if (upd_taken_i) begin
                    entries_d[wr_idx].target = wr_target;
                end
            end else if (upd_taken_i) begin
                valid_d[wr_idx]   = 1'b1;
                entries_d[wr_idx] = '{tag: wr_tag, target: wr_target, ctr: BTB_CTR_WEAK_TAKEN};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: the payload array has no reset; every read is qualified by valid_q.
    always_ff @(posedge clk_i) begin
        entries_q <= entries_d;
    end

endmodule

// File: rtl/pc_gen_btb.sv
// Fetch PC register and next-PC selection: trap > redirect > stall > BTB
// prediction > sequential increment.
module pc_gen_btb
    import cpu_pkg::*;
#(
    parameter int unsigned         WIDTH_P     = 32,
    parameter logic [WIDTH_P-1:0]  RESET_VEC_P = '0,
    parameter int unsigned         BTB_DEPTH_P = 16,
    parameter int unsigned         INC_P       = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    pc_gen_btb_if.slave bus
);

    localparam logic [WIDTH_P-1:0] ALIGN_MASK = PC_ALIGN_MASK[WIDTH_P-1:0];

    logic [WIDTH_P-1:0] pc_d, pc_q;
    logic               pred_taken;
    logic [WIDTH_P-1:0] pred_target;
    npc_src_t           npc_src;

    branch_target_buffer #(
        .WIDTH_P     (WIDTH_P),
        .BTB_DEPTH_P (BTB_DEPTH_P)
    ) u_btb (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .lookup_pc_i   (pc_q),
        .pred_taken_o  (pred_taken),
        .pred_target_o (pred_target),
        .upd_valid_i   (bus.upd_valid_i),
        .upd_pc_i      (bus.upd_pc_i),
        .upd_target_i  (bus.upd_target_i),
        .upd_taken_i   (bus.upd_taken_i),
        .flush_i       (bus.btb_flush_i)
    );

    // NOTE: default assignment first so no path through the block leaves npc_src unassigned (no latch).
    always_comb begin
        npc_src = NPC_SEQ;
        if (bus.trap_i) begin
            npc_src = NPC_TRAP;
        end else if (bus.redirect_i) begin
            npc_src = NPC_REDIRECT;
        end else if (bus.stall_i) begin
            npc_src = NPC_HOLD;
        end else if (pred_taken) begin
            npc_src = NPC_PRED;
        end
    end

    always_comb begin
        pc_d = pc_q + WIDTH_P'(INC_P);
        case (npc_src)
            NPC_TRAP:     pc_d = bus.trap_vec_i & ALIGN_MASK;
            NPC_REDIRECT: pc_d = bus.redirect_pc_i & ALIGN_MASK;
            NPC_HOLD:     pc_d = pc_q;
            NPC_PRED:     pc_d = pred_target;
            default:      ;
        endcase
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_VEC_P;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.pred_taken_o  = pred_taken;
    assign bus.pred_target_o = pred_target;

endmodule
